// File: rtl/tube_game_pkg.sv
// Shared definitions for the tube game controller: state encodings and
// datapath widths used by the sequencer and its step timer.
package tube_game_pkg;

  localparam int PERIOD_W = 4;
  localparam int SCORE_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_DYING = 3'd2,
    ST_OVER  = 3'd3,
    ST_PAUSE = 3'd4
  } state_e;

endpackage

// File: rtl/tube_step_timer.sv
// Tube-step timer: counts clk10 ticks and emits a one-cycle tube_step pulse
// every step_period ticks. The period is reloaded from the score at each wrap,
// so the tubes speed up as the score rises.
//   run  : advance the counter this cycle (pulse allowed on wrap)
//   hold : when not running, freeze counter and period; when neither run nor
//          hold, return to the idle layout (cnt=0, period=START_PERIOD)
module tube_step_timer
  import tube_game_pkg::*;
#(
  parameter int START_PERIOD  = 4,
  parameter int MIN_PERIOD    = 1,
  parameter int SPEEDUP_SHIFT = 3
) (
  input  logic                clk10,
  input  logic                clr,
  input  logic                run,
  input  logic                hold,
  input  logic [SCORE_W-1:0]  score,
  output logic                tube_step,
  output logic [PERIOD_W-1:0] step_period
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                step_q, step_d;
  logic [8:0]          score_shift;
  logic [8:0]          sat_diff;
  logic [8:0]          reload_wide;

  // Reload period: START - (score >> SHIFT), saturating at 0, floored at MIN.
  always_comb begin
    score_shift = {1'b0, score} >> SPEEDUP_SHIFT;
    sat_diff    = (9'(START_PERIOD) > score_shift) ? 9'(START_PERIOD) - score_shift : 9'd0;
    reload_wide = (sat_diff < 9'(MIN_PERIOD)) ? 9'(MIN_PERIOD) : sat_diff;
  end

  // Counter, period reload and step pulse for the next cycle.
  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    cnt_d    = cnt_q;
    period_d = period_q;
    step_d   = 1'b0;
    if (run) begin
      if (cnt_q == period_q - 1'b1) begin
        cnt_d    = '0;
        period_d = PERIOD_W'(reload_wide);
        step_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (!hold) begin
      cnt_d    = '0;
      period_d = PERIOD_W'(START_PERIOD);
    end
  end

  // Timer state registers, cleared asynchronously by clr.
  always_ff @(posedge clk10 or posedge clr) begin
    // NOTE: flops take non-blocking assignments; comb blocks use blocking.
    if (clr) begin
      cnt_q    <= '0;
      period_q <= PERIOD_W'(START_PERIOD);
      step_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      step_q   <= step_d;
    end
  end

  assign tube_step   = step_q;
  assign step_period = period_q;

endmodule

// File: rtl/tube_game_sequencer.sv
// Top-level game controller: IDLE/PLAY/DYING/OVER state machine driven by the
// start button and collision flag, tube mover control (tube_clr, game_end),
// score-dependent tube step timing and best-score tracking.
// Optional pause (start button during play) is enabled by TUBE_SEQ_PAUSE_EN.
module tube_game_sequencer
  import tube_game_pkg::*;
#(
  parameter int START_PERIOD  = 4,
  parameter int MIN_PERIOD    = 1,
  parameter int SPEEDUP_SHIFT = 3,
  parameter int DEATH_TICKS   = 20
) (
  input  logic                clk10,
  input  logic                clr,
  input  logic                start_btn,
  input  logic                collision,
  input  logic [SCORE_W-1:0]  score,
  output logic                tube_step,
  output logic                tube_clr,
  output logic                game_end,
  output logic [2:0]          state,
  output logic [PERIOD_W-1:0] step_period,
  output logic [SCORE_W-1:0]  best_score
);

  state_e             state_q, state_d;
  logic               start_prev_q;
  logic               start_rise;
  logic [7:0]         death_q, death_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic               tube_clr_q, tube_clr_d;
  logic               game_end_q, game_end_d;
  logic               run, hold;

  assign start_rise = start_btn & ~start_prev_q;

  // Next state, death countdown, best score and next-state-decoded outputs.
  always_comb begin
    state_d = state_q;
    death_d = death_q;
    best_d  = best_q;
    case (state_q)
      ST_IDLE: begin
        if (start_rise) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (collision) begin
          state_d = ST_DYING;
          death_d = 8'(DEATH_TICKS - 1);
        end
`ifdef TUBE_SEQ_PAUSE_EN
        else if (start_rise) begin
          state_d = ST_PAUSE;
        end
`endif
      end
      ST_DYING: begin
        if (death_q == '0) state_d = ST_OVER;
        else               death_d = death_q - 1'b1;
      end
      ST_OVER: begin
        if (start_rise) state_d = ST_IDLE;
      end
`ifdef TUBE_SEQ_PAUSE_EN
      ST_PAUSE: begin
        if (start_rise) state_d = ST_PLAY;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_OVER && state_q != ST_OVER && score > best_q) best_d = score;
    tube_clr_d = (state_d == ST_IDLE);
    game_end_d = (state_d != ST_PLAY);
  end

  // The timer advances only while play continues from a non-idle state; it
  // returns to the idle layout whenever the game heads back to IDLE.
  assign run  = (state_d == ST_PLAY) && (state_q != ST_IDLE);
  assign hold = (state_d != ST_IDLE);

  // FSM and output registers, cleared asynchronously by clr.
  always_ff @(posedge clk10 or posedge clr) begin
    if (clr) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b1;
      death_q      <= '0;
      best_q       <= '0;
      tube_clr_q   <= 1'b1;
      game_end_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_btn;
      death_q      <= death_d;
      best_q       <= best_d;
      tube_clr_q   <= tube_clr_d;
      game_end_q   <= game_end_d;
    end
  end

  tube_step_timer #(
    .START_PERIOD (START_PERIOD),
    .MIN_PERIOD   (MIN_PERIOD),
    .SPEEDUP_SHIFT(SPEEDUP_SHIFT)
  ) u_timer (
    .clk10      (clk10),
    .clr        (clr),
    .run        (run),
    .hold       (hold),
    .score      (score),
    .tube_step  (tube_step),
    .step_period(step_period)
  );

  assign state      = state_q;
  assign tube_clr   = tube_clr_q;
  assign game_end   = game_end_q;
  assign best_score = best_q;

endmodule

// File: tb/tb_tube_game_sequencer.sv
// Self-checking bench for tube_game_sequencer: reset/start vectors from a
// table, a scoreboard for the score-dependent step cadence, and hand-written
// sequences for dying, game over, best score, clr and (optionally) pause.
`timescale 1ns/1ps
module tb_tube_game_sequencer;

  localparam int T_START = 4;
  localparam int T_MIN   = 1;
  localparam int T_SHIFT = 3;
  localparam int T_DEATH = 20;

  logic       clk10 = 1'b0;
  logic       clr;
  logic       start_btn;
  logic       collision;
  logic [7:0] score;
  logic       tube_step;
  logic       tube_clr;
  logic       game_end;
  logic [2:0] state;
  logic [3:0] step_period;
  logic [7:0] best_score;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       start;
    logic       coll;
    logic [7:0] sc;
    logic [2:0] st;
    logic       step;
    logic       tclr;
    logic       gend;
    logic [3:0] per;
    logic [7:0] best;
  } vec_t;

  typedef struct {
    logic       step;
    logic [3:0] per;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];
  int   m_cnt;
  int   m_per;

  tube_game_sequencer #(
    .START_PERIOD (T_START),
    .MIN_PERIOD   (T_MIN),
    .SPEEDUP_SHIFT(T_SHIFT),
    .DEATH_TICKS  (T_DEATH)
  ) dut (
    .clk10      (clk10),
    .clr        (clr),
    .start_btn  (start_btn),
    .collision  (collision),
    .score      (score),
    .tube_step  (tube_step),
    .tube_clr   (tube_clr),
    .game_end   (game_end),
    .state      (state),
    .step_period(step_period),
    .best_score (best_score)
  );

  always #5 clk10 = ~clk10;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [2:0] st, input logic step,
                           input logic tclr, input logic gend, input logic [3:0] per,
                           input logic [7:0] best);
    check({name, ".state"}, 32'(state), 32'(st));
    check({name, ".tube_step"}, 32'(tube_step), 32'(step));
    check({name, ".tube_clr"}, 32'(tube_clr), 32'(tclr));
    check({name, ".game_end"}, 32'(game_end), 32'(gend));
    check({name, ".step_period"}, 32'(step_period), 32'(per));
    check({name, ".best_score"}, 32'(best_score), 32'(best));
  endtask

  task automatic tick();
    @(posedge clk10);
    #1;
  endtask

  function automatic int spec_period(input int s);
    int p;
    p = T_START - (s / (1 << T_SHIFT));
    if (p < T_MIN) p = T_MIN;
    return p;
  endfunction

  // Drive n PLAY cycles at a fixed score; expectations go through the queue.
  task automatic play_cycles(input int sc, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      score = 8'(sc);
      if (m_cnt == m_per - 1) begin
        e.step = 1'b1;
        m_cnt  = 0;
        m_per  = spec_period(sc);
      end else begin
        e.step = 1'b0;
        m_cnt++;
      end
      e.per = 4'(m_per);
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      check($sformatf("play sc=%0d tube_step", sc), 32'(tube_step), 32'(e.step));
      check($sformatf("play sc=%0d step_period", sc), 32'(step_period), 32'(e.per));
      check($sformatf("play sc=%0d state", sc), 32'(state), 32'd1);
    end
  endtask

  initial begin
    int dying_cnt;

    // Reset with the button held: no start until a fresh rising edge.
    clr = 1'b1; start_btn = 1'b1; collision = 1'b0; score = 8'd0;
    #2;
    check_all("reset", 3'd0, 1'b0, 1'b1, 1'b1, 4'd4, 8'd0);
    @(negedge clk10);
    clr = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 8'd0, 3'd0, 1'b0, 1'b1, 1'b1, 4'd4, 8'd0};
    vecs[1]  = '{1'b0, 1'b1, 8'd0, 3'd0, 1'b0, 1'b1, 1'b1, 4'd4, 8'd0};
    vecs[2]  = '{1'b1, 1'b0, 8'd0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd4, 8'd0};
    vecs[3]  = '{1'b1, 1'b0, 8'd0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd4, 8'd0};
    vecs[4]  = '{1'b0, 1'b0, 8'd0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd4, 8'd0};
    vecs[5]  = '{1'b0, 1'b0, 8'd0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd4, 8'd0};
    vecs[6]  = '{1'b0, 1'b0, 8'd0, 3'd1, 1'b1, 1'b0, 1'b0, 4'd4, 8'd0};
    vecs[7]  = '{1'b0, 1'b0, 8'd0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd4, 8'd0};
    vecs[8]  = '{1'b0, 1'b0, 8'd0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd4, 8'd0};
    vecs[9]  = '{1'b0, 1'b0, 8'd0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd4, 8'd0};
    vecs[10] = '{1'b0, 1'b0, 8'd0, 3'd1, 1'b1, 1'b0, 1'b0, 4'd4, 8'd0};

    for (int i = 0; i < 11; i++) begin
      start_btn = vecs[i].start;
      collision = vecs[i].coll;
      score     = vecs[i].sc;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].step, vecs[i].tclr,
                vecs[i].gend, vecs[i].per, vecs[i].best);
    end

    // Score-dependent cadence through the scoreboard.
    m_cnt = 0;
    m_per = T_START;
    play_cycles(0, 4);
    play_cycles(8, 8);
    play_cycles(24, 8);
    play_cycles(255, 6);
    play_cycles(0, 3);

`ifdef TUBE_SEQ_PAUSE_EN
    // Pause at cnt==2, idle 50 cycles with collisions ignored, then resume.
    for (int g = 0; g < 8 && m_cnt != 2; g++) play_cycles(0, 1);
    check("pause.align", 32'(m_cnt), 32'd2);
    start_btn = 1'b1;
    tick();
    check_all("pause.enter", 3'd4, 1'b0, 1'b0, 1'b1, 4'd4, 8'd0);
    for (int g = 0; g < 50; g++) begin
      start_btn = 1'b0;
      collision = g[0];
      tick();
      check("pause.state", 32'(state), 32'd4);
      check("pause.tube_step", 32'(tube_step), 32'd0);
    end
    collision = 1'b0;
    start_btn = 1'b1;
    tick();
    check_all("pause.resume", 3'd1, 1'b0, 1'b0, 1'b0, 4'd4, 8'd0);
    start_btn = 1'b0;
    tick();
    check("pause.first_step", 32'(tube_step), 32'd1);
    m_cnt = 0;
    m_per = T_START;
`endif

    // Collision on the wrap cycle: no step, DYING for DEATH_TICKS, then OVER.
    for (int g = 0; g < 8 && m_cnt != 3; g++) play_cycles(0, 1);
    check("coll.align", 32'(m_cnt), 32'd3);
    score = 8'd17;
    collision = 1'b1;
    tick();
    check_all("coll.enter", 3'd2, 1'b0, 1'b0, 1'b1, 4'd4, 8'd0);
    dying_cnt = 1;
    for (int g = 0; g < 40; g++) begin
      collision = g[0];
      start_btn = g[1];
      tick();
      if (state != 3'd2) break;
      dying_cnt++;
      check("dying.tube_step", 32'(tube_step), 32'd0);
    end
    start_btn = 1'b0;
    collision = 1'b0;
    check("dying.length", 32'(dying_cnt), 32'(T_DEATH));
    check_all("over1", 3'd3, 1'b0, 1'b0, 1'b1, 4'd4, 8'd17);

    // Restart needs two separate rises: OVER->IDLE, then IDLE->PLAY.
    tick();
    check("over.hold", 32'(state), 32'd3);
    start_btn = 1'b1;
    tick();
    check_all("over.to_idle", 3'd0, 1'b0, 1'b1, 1'b1, 4'd4, 8'd17);
    tick();
    check("idle.held_btn", 32'(state), 32'd0);
    start_btn = 1'b0;
    tick();
    start_btn = 1'b1;
    tick();
    check_all("game2.play", 3'd1, 1'b0, 1'b0, 1'b0, 4'd4, 8'd17);

    // Second game ends with a lower score: best stays.
    start_btn = 1'b0;
    score = 8'd9;
    collision = 1'b1;
    tick();
    check("game2.dying", 32'(state), 32'd2);
    collision = 1'b0;
    for (int g = 0; g < 40 && state == 3'd2; g++) tick();
    check_all("game2.over", 3'd3, 1'b0, 1'b0, 1'b1, 4'd4, 8'd17);

    // clr in the middle of DYING.
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    tick();
    start_btn = 1'b1;
    tick();
    check("game3.play", 32'(state), 32'd1);
    start_btn = 1'b0;
    collision = 1'b1;
    tick();
    collision = 1'b0;
    tick();
    tick();
    check("game3.dying", 32'(state), 32'd2);
    #2;
    clr = 1'b1;
    #1;
    check_all("clr.async", 3'd0, 1'b0, 1'b1, 1'b1, 4'd4, 8'd0);
    @(negedge clk10);
    clr = 1'b0;
    start_btn = 1'b1;
    tick();
    check_all("clr.resume", 3'd0, 1'b0, 1'b1, 1'b1, 4'd4, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
